// File: rtl/determ_pkg.sv
// ---------------------------------------------------------------------------
// determ_pkg
// Shared definitions for the deterministic bitstream blocks: state encoding
// for stream generators and the FXP fraction/one derivation used by every
// block that maps bits to +1/-1.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package determ_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Number of fractional bits of a signed FXP word (sign + int + frac).
  function automatic int calc_frac(input int bit_width, input int int_width);
    return bit_width - int_width - 1;
  endfunction

  // Integer encoding of +1.0 in that FXP format.
  function automatic longint calc_one(input int bit_width, input int int_width);
    return longint'(1) << calc_frac(bit_width, int_width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/determ_gen_fxp_if.sv
// ---------------------------------------------------------------------------
// determ_gen_fxp_if
// Load and stream handshakes of the FXP -> deterministic bitstream encoder.
//   in_valid/in_ready/in_value/in_len : value load (master -> encoder)
//   out_bit/out_valid/out_last/out_ready : bitstream (encoder -> consumer)
// Modports: master (source/consumer side), slave (encoder side).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface determ_gen_fxp_if #(
  parameter int BIT_WIDTH = 16,
  parameter int LEN_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIT_WIDTH-1:0]  in_value;
  logic [LEN_WIDTH-1:0]  in_len;
  logic                  out_bit;
  logic                  out_valid;
  logic                  out_last;
  logic                  out_ready;

  modport master (
    output in_valid, in_value, in_len, out_ready,
    input  in_ready, out_bit, out_valid, out_last
  );

  modport slave (
    input  in_valid, in_value, in_len, out_ready,
    output in_ready, out_bit, out_valid, out_last
  );
endinterface

`default_nettype wire

// File: rtl/determ_sd_step.sv
// ---------------------------------------------------------------------------
// determ_sd_step
// One combinational first-order sigma-delta step.
//   err      : accumulated signed error (BIT_WIDTH+2 bits)
//   x        : signed FXP target value
//   sd_bit   : emitted bit, 1 when err + x >= 0
//   err_next : err + x minus the +/-ONE that the emitted bit represents
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module determ_sd_step
  import determ_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int INT_WIDTH = 1
) (
  input  logic signed [BIT_WIDTH+1:0] err,
  input  logic signed [BIT_WIDTH-1:0] x,
  output logic                        sd_bit,
  output logic signed [BIT_WIDTH+1:0] err_next
);

  localparam logic signed [BIT_WIDTH+1:0] C_ONE =
    (BIT_WIDTH+2)'(calc_one(BIT_WIDTH, INT_WIDTH));

  logic signed [BIT_WIDTH+1:0] w_sum;

  always_comb begin
    w_sum    = err + {{2{x[BIT_WIDTH-1]}}, x};
    sd_bit   = ~w_sum[BIT_WIDTH+1];
    err_next = sd_bit ? (w_sum - C_ONE) : (w_sum + C_ONE);
  end

endmodule

`default_nettype wire

// File: rtl/determ_gen_fxp.sv
// ---------------------------------------------------------------------------
// determ_gen_fxp
// Encodes one signed FXP value per load into a deterministic bitstream of
// programmable length L (bit 1 = +1, bit 0 = -1) using sigma-delta error
// feedback; the stream mean equals x within 2/L.
//   CLK, RST : clock (rising edge), asynchronous active-high reset
//   bus      : determ_gen_fxp_if.slave (load + stream handshakes)
// Build option: DETERM_GEN_SAT_EN clamps in_value to [-ONE, +ONE] at load;
// without it an out-of-range load is flagged by an assertion.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module determ_gen_fxp
  import determ_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int INT_WIDTH = 1,
  parameter int LEN_WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  determ_gen_fxp_if.slave  bus
);

  localparam logic signed [BIT_WIDTH+1:0] C_ONE =
    (BIT_WIDTH+2)'(calc_one(BIT_WIDTH, INT_WIDTH));
  localparam logic signed [BIT_WIDTH+1:0] C_NEG_ONE = -C_ONE;
  localparam logic [LEN_WIDTH:0] C_CNT_ONE = (LEN_WIDTH+1)'(1);
  localparam logic [LEN_WIDTH:0] C_CNT_MAX = C_CNT_ONE << LEN_WIDTH;

  state_t                      r_state, w_state_next;
  logic signed [BIT_WIDTH-1:0] r_x, w_x_next;
  logic signed [BIT_WIDTH+1:0] r_err, w_err_next;
  logic [LEN_WIDTH:0]          r_cnt, w_cnt_next;

  logic                        w_sd_bit;
  logic signed [BIT_WIDTH+1:0] w_err_step;
  logic signed [BIT_WIDTH-1:0] w_load_value;
  logic signed [BIT_WIDTH+1:0] w_in_ext;
  logic                        w_in_fire;
  logic                        w_out_fire;

  determ_sd_step #(
    .BIT_WIDTH (BIT_WIDTH),
    .INT_WIDTH (INT_WIDTH)
  ) u_sd_step (
    .err      (r_err),
    .x        (r_x),
    .sd_bit   (w_sd_bit),
    .err_next (w_err_step)
  );

  assign w_in_ext = {{2{bus.in_value[BIT_WIDTH-1]}}, bus.in_value};

`ifdef DETERM_GEN_SAT_EN
  always_comb begin
    w_load_value = bus.in_value;
    if (w_in_ext > C_ONE) begin
      w_load_value = C_ONE[BIT_WIDTH-1:0];
    end else if (w_in_ext < C_NEG_ONE) begin
      w_load_value = C_NEG_ONE[BIT_WIDTH-1:0];
    end
  end
`else
  assign w_load_value = bus.in_value;

  a_load_in_range : assert property (@(posedge CLK) disable iff (RST)
    w_in_fire |-> ((w_in_ext <= C_ONE) && (w_in_ext >= C_NEG_ONE)));
`endif

  assign bus.out_valid = (r_state == RUN);
  assign bus.out_bit   = (r_state == RUN) && w_sd_bit;
  assign bus.out_last  = (r_state == RUN) && (r_cnt == C_CNT_ONE);
  // The last-bit handshake frees the encoder in the same cycle, so a new
  // load can follow the previous stream without a gap.
  assign bus.in_ready  = (r_state == IDLE) ||
                         (bus.out_valid && bus.out_last && bus.out_ready);

  assign w_in_fire  = bus.in_valid && bus.in_ready;
  assign w_out_fire = bus.out_valid && bus.out_ready;

  always_comb begin
    w_state_next = r_state;
    w_x_next     = r_x;
    w_err_next   = r_err;
    w_cnt_next   = r_cnt;
    if (w_out_fire) begin
      w_err_next = w_err_step;
      w_cnt_next = r_cnt - C_CNT_ONE;
      if (r_cnt == C_CNT_ONE) begin
        w_state_next = IDLE;
      end
    end
    // A load overrides the bit-accept update, including the error carry.
    if (w_in_fire) begin
      w_state_next = RUN;
      w_x_next     = w_load_value;
      w_err_next   = '0;
      w_cnt_next   = (bus.in_len == '0) ? C_CNT_MAX : {1'b0, bus.in_len};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_err   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_x     <= w_x_next;
      r_err   <= w_err_next;
      r_cnt   <= w_cnt_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_determ_gen_fxp.sv
// ---------------------------------------------------------------------------
// tb_determ_gen_fxp
// Directed self-checking bench for determ_gen_fxp (BIT_WIDTH=16,
// INT_WIDTH=1, LEN_WIDTH=8, ONE=0x4000).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_determ_gen_fxp;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  determ_gen_fxp_if #(.BIT_WIDTH(16), .LEN_WIDTH(8)) bus ();

  determ_gen_fxp #(
    .BIT_WIDTH (16),
    .INT_WIDTH (1),
    .LEN_WIDTH (8)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a load while idle; returns one cycle later with bit 0 on the bus.
  task automatic load(input logic [15:0] value, input logic [7:0] len);
    bus.in_valid = 1'b1;
    bus.in_value = value;
    bus.in_len   = len;
    #1;
    chk("load_ready", {31'b0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    #1;
  endtask

  // Check bits [first..last] of a stream; pattern bit i is stream bit i.
  task automatic check_bits(input string tag, input logic [7:0] pattern,
                            input int first, input int last, input int len);
    for (int i = first; i <= last; i++) begin
      chk({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
      chk({tag, "_bit"},   {31'b0, bus.out_bit},   {31'b0, pattern[i]});
      chk({tag, "_last"},  {31'b0, bus.out_last},  (i == len - 1) ? 32'd1 : 32'd0);
      tick();
      #1;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_idle_valid"}, {31'b0, bus.out_valid}, 32'd0);
    chk({tag, "_idle_ready"}, {31'b0, bus.in_ready},  32'd1);
  endtask

  initial begin
    int ones;
    int last_idx;
    int last_cnt;

    checks = 0;
    errors = 0;
    RST = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_value  = '0;
    bus.in_len    = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_last",  {31'b0, bus.out_last},  32'd0);
    chk("rst_bit",   {31'b0, bus.out_bit},   32'd0);
    chk("rst_ready", {31'b0, bus.in_ready},  32'd1);
    RST = 1'b0;
    tick();

    // +1 -> all ones
    load(16'h4000, 8'd8);
    check_bits("pos1", 8'hFF, 0, 7, 8);
    check_idle("pos1");

    // -1 -> all zeros
    load(16'hC000, 8'd8);
    check_bits("neg1", 8'h00, 0, 7, 8);
    check_idle("neg1");

    // 0 -> 1,0,1,0,...
    load(16'h0000, 8'd8);
    check_bits("zero", 8'h55, 0, 7, 8);
    check_idle("zero");

    // +0.5 -> 1,1,0,1,1,1,0,1 with a 3-cycle stall before bit index 3
    load(16'h2000, 8'd8);
    check_bits("half", 8'hBB, 0, 2, 8);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("stall_bit",   {31'b0, bus.out_bit},   32'd1);
      chk("stall_ready", {31'b0, bus.in_ready},  32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check_bits("half", 8'hBB, 3, 7, 8);
    check_idle("half");

    // Back-to-back: second load on the last bit of the first stream
    load(16'h4000, 8'd4);
    check_bits("b2b_a", 8'h0F, 0, 2, 4);
    bus.in_valid = 1'b1;
    bus.in_value = 16'hC000;
    bus.in_len   = 8'd4;
    #1;
    chk("b2b_last_a",  {31'b0, bus.out_last},  32'd1);
    chk("b2b_bit_a",   {31'b0, bus.out_bit},   32'd1);
    chk("b2b_ready_a", {31'b0, bus.in_ready},  32'd1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    check_bits("b2b_b", 8'h00, 0, 3, 4);
    check_idle("b2b");

    // Asynchronous reset in the middle of a stream (at bit 5)
    load(16'h0000, 8'd8);
    check_bits("abort", 8'h55, 0, 3, 8);
    RST = 1'b1;
    #1;
    chk("abort_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("abort_ready", {31'b0, bus.in_ready},  32'd1);
    chk("abort_last",  {31'b0, bus.out_last},  32'd0);
    tick();
    RST = 1'b0;
    tick();
    load(16'h0000, 8'd8);
    check_bits("restart", 8'h55, 0, 7, 8);
    check_idle("restart");

    // in_len = 0 -> 256 bits, mean exactly zero
    load(16'h0000, 8'd0);
    ones = 0;
    last_idx = -1;
    last_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      if (bus.out_valid !== 1'b1) begin
        chk("long_valid", {31'b0, bus.out_valid}, 32'd1);
      end
      if (bus.out_bit === 1'b1) ones++;
      if (bus.out_last === 1'b1) begin
        last_idx = i;
        last_cnt++;
      end
      tick();
      #1;
    end
    chk("long_ones",     ones,     32'd128);
    chk("long_last_idx", last_idx, 32'd255);
    chk("long_last_cnt", last_cnt, 32'd1);
    check_idle("long");

`ifdef DETERM_GEN_SAT_EN
    // Out-of-range values are clamped to +/-1
    load(16'h7FFF, 8'd8);
    check_bits("sat_pos", 8'hFF, 0, 7, 8);
    check_idle("sat_pos");
    load(16'h8000, 8'd8);
    check_bits("sat_neg", 8'h00, 0, 7, 8);
    check_idle("sat_neg");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/determ_gen_fxp.md
Name: determ_gen_fxp

Overview:
- Encoder from signed fixed-point (FXP) to deterministic bitstream, using the bitstream convention bit 1 = +1, bit 0 = -1.
- Takes one FXP value x in [-1, 1] per transaction and emits a stream of a programmable length L. The mean of the ±1 bits equals x, with an error of at most 2/L.
- Uses first-order sigma-delta error feedback.
- Feeds the deterministic arithmetic blocks (add/sub/mult) from FXP sources.

Parameters:
- BIT_WIDTH, 16, total FXP width, two's complement.
- INT_WIDTH, 1, integer bits excluding sign. FRAC = BIT_WIDTH - INT_WIDTH - 1; ONE = 2^FRAC.
- LEN_WIDTH, 8, width of the stream-length input.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- in_valid  input  1  load request.
- in_ready  output  1  load accepted when in_valid && in_ready.
- in_value  input  BIT_WIDTH  signed FXP value x.
- in_len  input  LEN_WIDTH  stream length L; 0 encodes 2^LEN_WIDTH.
- out_bit  output  1  current stream bit.
- out_valid  output  1  out_bit is valid.
- out_last  output  1  final bit of the current stream.
- out_ready  input  1  consumer accepts the bit when out_valid && out_ready.

Behaviour:
- Registers:
  - state ∈ {IDLE, RUN}.
  - x_reg: BIT_WIDTH bits.
  - err: signed, BIT_WIDTH+2 bits.
  - cnt: LEN_WIDTH+1 bits.
- Reset, asynchronous, takes effect immediately and may occur mid-stream:
  - state=IDLE, x_reg=0, err=0, cnt=0.
  - Outputs: out_valid=0, out_last=0, out_bit=0, in_ready=1.
  - Any stream in progress is aborted with no further bits.
- Combinational outputs:
  - s = err + sign-extend(x_reg).
  - out_bit = (state==RUN) && (s >= 0).
  - out_valid = (state==RUN).
  - out_last = (state==RUN) && (cnt==1).
  - in_ready = (state==IDLE) || (out_valid && out_last && out_ready).
- Load (in handshake) at edge T:
  - x_reg <= x, err <= 0, cnt <= (in_len==0 ? 2^LEN_WIDTH : in_len), state <= RUN.
  - The first bit is valid from cycle T+1, so latency is 1 cycle.
- Bit accepted (out handshake):
  - err <= s - (out_bit ? ONE : -ONE).
  - cnt <= cnt - 1.
  - If this was the last bit and no simultaneous load: state <= IDLE.
- Last-bit handshake and load in the same cycle:
  - The load wins: the new stream starts next cycle with no gap.
  - err is reset to 0, not carried over.
- Backpressure: while out_valid && !out_ready, all registers hold and out_bit is stable.
- in_valid while in RUN and not on the last handshake: ignored, because in_ready=0.
- Bounds: |err| <= ONE holds for in-range x. The final value satisfies |Σ(±1) - L·x/ONE| <= 2.

Optional Feature:
- Macro: DETERM_GEN_SAT_EN.
- Defined: in_value is clamped to [-ONE, +ONE] at load, so out-of-range inputs produce all-ones or all-zeros streams.
- Undefined:
  - in_value is loaded unmodified; an in-range input is a precondition.
  - A simulation-only assertion flags an out-of-range load.
  - Output for out-of-range x is unspecified.

Decomposition:
- Shared package determ_pkg holds:
  - the state encoding (IDLE, RUN);
  - the FRAC/ONE derivation as a constant function of BIT_WIDTH and INT_WIDTH, reused by the deterministic ±1 mapping blocks.
- One natural sub-module, determ_sd_step, is purely combinational:
  - inputs err, x; outputs bit, err_next;
  - instantiated once.
- Handshake FSM and counter stay in the top module.

Test Plan (BIT_WIDTH=16, INT_WIDTH=1, ONE=0x4000, out_ready=1 unless stated):
- in_value=0x4000, in_len=8 -> 8 bits all 1; out_last on the 8th; then in_ready=1 and out_valid=0.
- in_value=0xC000 (-1), in_len=8 -> 8 bits all 0. in_value=0x0000, in_len=8 -> 1,0,1,0,1,0,1,0.
- in_value=0x2000 (+0.5), in_len=8 -> 1,1,0,1,1,1,0,1. Drop out_ready for 3 cycles after bit 3 -> out_bit held and the sequence is unchanged.
- Back-to-back: second load (0xC000, len 4) presented on the last bit of a 0x4000/len 4 stream -> 8 contiguous valid cycles, 1111 then 0000, out_last pulses at cycles 4 and 8.
- Assert RST at bit 5 of a len-8 stream -> out_valid=0 immediately, in_ready=1. A fresh load of 0x0000 then restarts at 1,0,….
- in_len=0, in_value=0x0000 -> 256 bits, mean exactly 0. With DETERM_GEN_SAT_EN, in_value=0x7FFF, len 8 -> all ones.
